// File: rtl/gbalu_pkg.sv
// Shared types for the multi-accumulator Game Boy style ALU.
package gbalu_pkg;

   typedef enum logic [2:0] {
      OpAdd = 3'b000,
      OpAdc = 3'b001,
      OpSub = 3'b010,
      OpSbc = 3'b011,
      OpAnd = 3'b100,
      OpXor = 3'b101,
      OpOr  = 3'b110,
      OpCp  = 3'b111
   } op_e;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_H = 1;
   localparam int unsigned FLAG_C = 0;

   // Field order matches the FLAG_* bit indices.
   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

endpackage

// File: rtl/gbalu_core.sv
// Combinational ALU: one op on (a, b, carry-in) producing result and Z/N/H/C.
module gbalu_core
   import gbalu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              c_i,
   input  op_e               op_i,
   output logic [DATA_W-1:0] result_o,
   output flags_t            flags_o
);

   localparam int unsigned HW = DATA_W / 2;

   logic              cin;
   logic [DATA_W:0]   wide;
   logic [HW:0]       half;

   // Top bit of each extended sum/difference is the carry out or the borrow.
   always_comb begin
      cin      = ((op_i == OpAdc) || (op_i == OpSbc)) ? c_i : 1'b0;
      wide     = '0;
      half     = '0;
      result_o = '0;
      flags_o  = '0;
      unique case (op_i)
         OpAdd, OpAdc: begin
            wide      = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin};
            half      = {1'b0, a_i[HW-1:0]} + {1'b0, b_i[HW-1:0]} + {{HW{1'b0}}, cin};
            result_o  = wide[DATA_W-1:0];
            flags_o.h = half[HW];
            flags_o.c = wide[DATA_W];
         end
         OpSub, OpSbc, OpCp: begin
            wide      = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin};
            half      = {1'b0, a_i[HW-1:0]} - {1'b0, b_i[HW-1:0]} - {{HW{1'b0}}, cin};
            result_o  = wide[DATA_W-1:0];
            flags_o.n = 1'b1;
            flags_o.h = half[HW];
            flags_o.c = wide[DATA_W];
         end
         OpAnd: begin
            result_o  = a_i & b_i;
            flags_o.h = 1'b1;
         end
         OpXor: result_o = a_i ^ b_i;
         OpOr:  result_o = a_i | b_i;
         default: ;
      endcase
      flags_o.z = (result_o == '0);
   end

endmodule

// File: rtl/gbalu_multi.sv
// Three-stage (IN/EX/WB) ALU with NUM_ACC independent accumulators and WB->EX forwarding.
module gbalu_multi
   import gbalu_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NUM_ACC = 4,
   localparam int unsigned SEL_W  = $clog2(NUM_ACC)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SEL_W+3:0]    instruction,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                valid,
   output logic [DATA_W+3:0]   probe,
   output logic                probe_valid
);

   logic              in_v_q, in_v_d;
   logic [SEL_W-1:0]  in_sel_q, in_sel_d;
   logic              in_load_q, in_load_d;
   logic [2:0]        in_op_q, in_op_d;
   logic [DATA_W-1:0] in_data_q, in_data_d;

   logic              wb_v_q, wb_v_d;
   logic [SEL_W-1:0]  wb_sel_q, wb_sel_d;
   logic [DATA_W-1:0] wb_acc_q, wb_acc_d;
   flags_t            wb_flags_q, wb_flags_d;

   logic [DATA_W-1:0] acc_q [NUM_ACC];
   logic [DATA_W-1:0] acc_d [NUM_ACC];
   flags_t            flags_q [NUM_ACC];
   flags_t            flags_d [NUM_ACC];

   logic [DATA_W+3:0] probe_q, probe_d;
   logic              probe_valid_q, probe_valid_d;

   logic              fwd;
   logic [DATA_W-1:0] ex_a;
   flags_t            ex_flags;
   logic [DATA_W-1:0] core_result;
   flags_t            core_flags;

   // The WB entry has not reached the arrays yet, so a same-sel EX op must take it from WB.
   always_comb begin
      fwd      = wb_v_q && (wb_sel_q == in_sel_q);
      ex_a     = fwd ? wb_acc_q   : acc_q[in_sel_q];
      ex_flags = fwd ? wb_flags_q : flags_q[in_sel_q];
   end

   gbalu_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .a_i      (ex_a),
      .b_i      (in_data_q),
      .c_i      (ex_flags[FLAG_C]),
      .op_i     (op_e'(in_op_q)),
      .result_o (core_result),
      .flags_o  (core_flags)
   );

   always_comb begin
      in_v_d    = valid;
      in_sel_d  = instruction[SEL_W+3:4];
      in_load_d = instruction[3];
      in_op_d   = instruction[2:0];
      in_data_d = data_in;

      wb_v_d   = in_v_q;
      wb_sel_d = in_sel_q;
      if (in_load_q) begin
         wb_acc_d   = in_data_q;
         wb_flags_d = ex_flags;
      end else begin
         wb_acc_d   = (op_e'(in_op_q) == OpCp) ? ex_a : core_result;
         wb_flags_d = core_flags;
      end

      acc_d         = acc_q;
      flags_d       = flags_q;
      probe_d       = probe_q;
      probe_valid_d = 1'b0;
      if (wb_v_q) begin
         acc_d[wb_sel_q]   = wb_acc_q;
         flags_d[wb_sel_q] = wb_flags_q;
         probe_d           = {wb_acc_q, wb_flags_q};
         probe_valid_d     = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         in_v_q        <= 1'b0;
         in_sel_q      <= '0;
         in_load_q     <= 1'b0;
         in_op_q       <= '0;
         in_data_q     <= '0;
         wb_v_q        <= 1'b0;
         wb_sel_q      <= '0;
         wb_acc_q      <= '0;
         wb_flags_q    <= '0;
         probe_q       <= '0;
         probe_valid_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_ACC; i++) begin
            acc_q[i]   <= '0;
            flags_q[i] <= '0;
         end
      end else begin
         in_v_q        <= in_v_d;
         in_sel_q      <= in_sel_d;
         in_load_q     <= in_load_d;
         in_op_q       <= in_op_d;
         in_data_q     <= in_data_d;
         wb_v_q        <= wb_v_d;
         wb_sel_q      <= wb_sel_d;
         wb_acc_q      <= wb_acc_d;
         wb_flags_q    <= wb_flags_d;
         probe_q       <= probe_d;
         probe_valid_q <= probe_valid_d;
         acc_q         <= acc_d;
         flags_q       <= flags_d;
      end
   end

   assign probe       = probe_q;
   assign probe_valid = probe_valid_q;

endmodule

// File: tb/tb_gbalu_multi.sv
// Scoreboard bench: driver pushes model results, a negedge monitor pops and compares.
module tb_gbalu_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  instruction;
   logic [7:0]  data_in;
   logic        valid;
   logic [11:0] probe;
   logic        probe_valid;

   logic [5:0]  instr16;
   logic [15:0] data16;
   logic        valid16;
   logic [19:0] probe16;
   logic        probe_valid16;

   always #5 clk = ~clk;

   gbalu_multi #(
      .DATA_W  (8),
      .NUM_ACC (4)
   ) dut (
      .clock       (clk),
      .reset       (reset),
      .instruction (instruction),
      .data_in     (data_in),
      .valid       (valid),
      .probe       (probe),
      .probe_valid (probe_valid)
   );

   gbalu_multi #(
      .DATA_W  (16),
      .NUM_ACC (4)
   ) dut16 (
      .clock       (clk),
      .reset       (reset),
      .instruction (instr16),
      .data_in     (data16),
      .valid       (valid16),
      .probe       (probe16),
      .probe_valid (probe_valid16)
   );

   typedef struct {
      logic [11:0] val;
      int          due;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_issued = 0;
   int          n_pulses = 0;

   int          macc [4];
   logic [3:0]  mflags [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
   endtask

   // Reference: sequential semantics of each op with plain integer arithmetic.
   function automatic logic [11:0] model_step(input int sel, input bit load, input int op,
                                              input int d);
      int a, c, r;
      bit n, h, cy, wr;
      logic [7:0] av;
      a  = macc[sel];
      c  = int'(mflags[sel][0]);
      wr = 1'b1;
      n  = 1'b0;
      h  = 1'b0;
      cy = 1'b0;
      r  = 0;
      if (load) begin
         macc[sel] = d;
      end else begin
         case (op)
            0: begin r = a + d; h = (a % 16 + d % 16) > 15; cy = r > 255; end
            1: begin r = a + d + c; h = (a % 16 + d % 16 + c) > 15; cy = r > 255; end
            2, 7: begin
               r = a - d; n = 1'b1; h = (a % 16) < (d % 16); cy = a < d; wr = (op != 7);
            end
            3: begin
               r = a - d - c; n = 1'b1; h = (a % 16) < (d % 16 + c); cy = a < (d + c);
            end
            4: begin r = a & d; h = 1'b1; end
            5: r = a ^ d;
            default: r = a | d;
         endcase
         r = r & 255;
         mflags[sel] = {(r == 0), n, h, cy};
         if (wr) macc[sel] = r;
      end
      av = macc[sel][7:0];
      return {av, mflags[sel]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         macc[i]   = 0;
         mflags[i] = 4'h0;
      end
   endtask

   // Called just after a negedge; the DUT samples on the next posedge.
   task automatic issue(input int sel, input bit load, input int op, input int d);
      exp_t e;
      instruction = {sel[1:0], load, op[2:0]};
      data_in     = d[7:0];
      valid       = 1'b1;
      e.val       = model_step(sel, load, op, d);
      e.due       = cyc + 3;
      sb_q.push_back(e);
      n_issued++;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!reset && probe_valid) begin
         n_pulses++;
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'(probe), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("probe", 32'(probe), 32'(e.val));
            check("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      int n16;
      logic [19:0] last16;
      reset       = 1'b1;
      valid       = 1'b0;
      instruction = '0;
      data_in     = '0;
      instr16     = '0;
      data16      = '0;
      valid16     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      // valid during the last reset cycle must be dropped
      instruction = 6'b00_1_000;
      data_in     = 8'h55;
      valid       = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      reset = 1'b0;
      check("reset_probe", 32'(probe), 32'd0);
      check("reset_probe_valid", 32'(probe_valid), 32'd0);
      idle(4);

      issue(0, 1, 0, 8'h3A);
      issue(0, 0, 0, 8'hC6);
      issue(1, 1, 0, 8'h0F);
      issue(1, 0, 0, 8'h01);
      issue(1, 0, 1, 8'hFF);
      issue(2, 1, 0, 8'h10);
      issue(2, 0, 2, 8'h01);
      issue(2, 0, 7, 8'h20);
      issue(2, 0, 3, 8'h00);
      issue(0, 1, 0, 8'h01);
      issue(3, 1, 0, 8'hFF);
      issue(0, 0, 0, 8'h01);
      issue(3, 0, 0, 8'h01);
      drain();

      // Reset right after a valid ADD: nothing may retire.
      issue(1, 0, 0, 8'h22);
      reset = 1'b1;
      sb_q.delete();
      n_issued--;
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      idle(5);
      check("post_reset_probe", 32'(probe), 32'd0);
      for (int s = 0; s < 4; s++) issue(s, 0, 0, 0);
      drain();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 7)
            issue($urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom_range(0, 7),
                  $urandom_range(0, 255));
         else
            idle(1);
      end
      drain();
      check("pulse_count", 32'(n_pulses), 32'(n_issued));

      // 16-bit instance: H must come from bit 7.
      instr16 = 6'b00_1_000;
      data16  = 16'h00FF;
      valid16 = 1'b1;
      @(negedge clk);
      instr16 = 6'b00_0_000;
      data16  = 16'h0001;
      @(negedge clk);
      valid16 = 1'b0;
      n16     = 0;
      last16  = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (probe_valid16) begin
            n16++;
            last16 = probe16;
         end
      end
      check("w16_pulses", 32'(n16), 32'd2);
      check("w16_add", 32'(last16), 32'h01002);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
